pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
- Parametrised successor to the combinational branch/next-PC decision logic.
- Owns the fetch PC register.
- Predicts the next PC at fetch with a direct-mapped branch target table of 2-bit saturating counters.
- Resolves control-flow instructions from the execute stage, including unsigned branches, and issues a single-cycle flush/redirect on mispredict.

Parameters:
XLEN, 32, datapath/PC width in bits.
BHT_DEPTH, 64, table entries; power of two, min 2; IDX = log2(BHT_DEPTH).
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hold fetch PC this cycle.
pc  output  XLEN  current fetch PC (register).
pred_taken  output  1  fetch prediction for pc.
pred_target  output  XLEN  predicted next PC for pc.
ex_valid  input  1  execute-stage instruction valid.
ex_pc  input  XLEN  PC of execute-stage instruction.
ex_op7  input  7  opcode.
ex_b_t  input  3  funct3.
ex_data1  input  XLEN  rs1 value.
ex_imm  input  XLEN  sign-extended immediate.
ex_breq  input  1  rs1==rs2.
ex_brlt  input  1  rs1<rs2 signed.
ex_brltu  input  1  rs1<rs2 unsigned.
ex_pred_taken  input  1  prediction carried down the pipe.
ex_pred_target  input  XLEN  predicted next PC carried down the pipe.
flush  output  1  mispredict: kill younger instructions.
redirect_pc  output  XLEN  correct next PC when flush=1.

Behaviour:
- Reset (rst_n low, async):
  - pc=RESET_PC; all entries valid=0, counter=2'b01.
  - flush forced 0 while rst_n low.
  - Release is synchronous to the next clk edge; first fetch is RESET_PC.
- Entry contents: valid, tag=PC[XLEN-1:IDX+2], target[XLEN], ctr[2]. Index = PC[IDX+1:2].
- Fetch (combinational from pc and table state):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : pc+4 (mod 2^XLEN).
- Resolve (combinational, when ex_valid=1):
  - JAL (1101111) and JALR (1100111): taken=1.
  - BRANCH (1100011), by funct3:
    - 000 beq: breq.
    - 001 bne: !breq.
    - 100 blt: brlt.
    - 101 bge: !brlt.
    - 110 bltu: brltu.
    - 111 bgeu: !brltu.
    - 010/011: taken=0 (no trap).
  - Other opcode: taken=0.
  - actual_target: JALR = (ex_data1+ex_imm) & ~1; otherwise ex_pc+ex_imm. Wraps mod 2^XLEN.
  - actual_next = taken ? actual_target : ex_pc+4.
- Mispredict and redirect:
  - mispredict = ex_valid & (ex_pred_target != actual_next).
  - flush = mispredict; redirect_pc = actual_next. Zero-cycle latency, same cycle.
  - redirect_pc is don't-care when flush=0.
- PC update at clk edge, priority order:
  1. reset;
  2. mispredict: pc<=redirect_pc, overrides stall;
  3. stall: hold;
  4. else pc<=pred_target.
- Table update at clk edge when ex_valid (not gated by stall); idx/tag from ex_pc:
  - Branch, entry hit:
    - taken: ctr increments, saturating at 11; target<=actual_target.
    - not taken: ctr decrements, saturating at 00.
  - Branch, entry miss:
    - taken: allocate/replace; valid=1, tag, target, ctr=2'b10.
    - not taken: no change.
  - JAL/JALR: allocate or overwrite; valid=1, ctr=2'b11, target=actual_target.
  - Non-control instruction with a hitting entry (alias/self-modified code): valid<=0. Otherwise no change.
- Simultaneous fetch read and resolve write to the same index: fetch sees the pre-update entry; the write is visible next cycle.
- Reset asserted mid-operation: clears state immediately regardless of stall/ex_valid.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 mid-run with stall=1, then release.
  - Required: pc=0 during reset; pc=0,4,8 on successive cycles; pred_taken=0; flush=0 throughout.
- Cold taken beq:
  - Stimulus: ex_pc=0x10, op7=1100011, b_t=000, breq=1, imm=0x20, ex_pred_target=0x14.
  - Required: flush=1, redirect_pc=0x30; next pc=0x30.
  - Follow-up: fetch of 0x10 then predicts taken, target 0x30, ctr=10.
- Counter hysteresis:
  - Stimulus: same branch resolved not-taken once, then not-taken again.
  - Required: after the first, ctr 11->10 and still predicts taken; after the second, ctr=01 and predicts not taken (pred_target=0x14).
- JALR:
  - Stimulus: data1=0x1001, imm=0x4, ex_pc=0x40, ex_pred_target=0x44.
  - Required: redirect_pc=0x1004 (LSB cleared); entry ctr=11.
- Unsigned branches:
  - Stimulus: bltu with brltu=1, brlt=0; then bgeu with brltu=1.
  - Required: taken; then not taken. b_t=010: not taken, no table change.
- Stall vs flush:
  - Stimulus: stall=1 with mispredict in the same cycle.
  - Required: pc<=redirect_pc.
  - Stimulus: stall=1 with correct prediction.
  - Required: pc holds for the stall duration.

Source files
------------

// File: rtl/pc_predict_if.sv
// Fetch/execute bundle between the pipeline and the PC predict unit.
// The pipeline (master) drives stall and the resolved execute-stage fields;
// the unit (slave) returns the fetch PC, its prediction and the redirect.
interface pc_predict_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [6:0]      ex_op7;
    logic [2:0]      ex_b_t;
    logic [XLEN-1:0] ex_data1;
    logic [XLEN-1:0] ex_imm;
    logic            ex_breq;
    logic            ex_brlt;
    logic            ex_brltu;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output stall, ex_valid, ex_pc, ex_op7, ex_b_t, ex_data1, ex_imm,
               ex_breq, ex_brlt, ex_brltu, ex_pred_taken, ex_pred_target,
        input  pc, pred_taken, pred_target, flush, redirect_pc
    );

    modport slave (
        input  stall, ex_valid, ex_pc, ex_op7, ex_b_t, ex_data1, ex_imm,
               ex_breq, ex_brlt, ex_brltu, ex_pred_taken, ex_pred_target,
        output pc, pred_taken, pred_target, flush, redirect_pc
    );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped branch target table of 2-bit
// saturating counters. Predicts the next PC at fetch, resolves control flow
// from execute and issues a same-cycle flush/redirect on mispredict.
module pc_predict_unit #(
    parameter int              XLEN      = 32,
    parameter int              BHT_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_predict_if.slave bus
);
    localparam int IDX   = $clog2(BHT_DEPTH);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter saturation helpers
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Table storage: valid/ctr are control (reset), tag/target are data
    logic             valid_q  [BHT_DEPTH];
    logic [1:0]       ctr_q    [BHT_DEPTH];
    logic [TAG_W-1:0] tag_q    [BHT_DEPTH];
    logic [XLEN-1:0]  target_q [BHT_DEPTH];

    logic [XLEN-1:0]  pc_q;

    // Fetch-side lookup
    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;
    logic [XLEN-1:0]  f_target;

    // Execute-side resolution
    logic [IDX-1:0]   e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             is_branch;
    logic             is_jump;
    logic             taken;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  actual_target;
    logic [XLEN-1:0]  actual_next;
    logic             mispredict;

    // Table write controls
    logic             tbl_we;
    logic             vld_clr;
    logic             ctr_we;
    logic [1:0]       ctr_d;

    assign f_idx = pc_q[IDX+1:2];
    assign f_tag = pc_q[XLEN-1:IDX+2];
    assign e_idx = bus.ex_pc[IDX+1:2];
    assign e_tag = bus.ex_pc[XLEN-1:IDX+2];

    // Fetch prediction from the current PC and the pre-update table contents
    always_comb begin
        f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        f_taken  = f_hit && ctr_q[f_idx][1];
        f_target = f_taken ? target_q[f_idx] : pc_q + XLEN'(4);
    end

    // Resolve direction and target of the execute-stage instruction
    always_comb begin
        is_branch = (bus.ex_op7 == OP_BRANCH);
        is_jump   = (bus.ex_op7 == OP_JAL) || (bus.ex_op7 == OP_JALR);
        taken     = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else if (is_branch) begin
            case (bus.ex_b_t)
                3'b000:  taken = bus.ex_breq;
                3'b001:  taken = !bus.ex_breq;
                3'b100:  taken = bus.ex_brlt;
                3'b101:  taken = !bus.ex_brlt;
                3'b110:  taken = bus.ex_brltu;
                3'b111:  taken = !bus.ex_brltu;
                default: taken = 1'b0;
            endcase
        end
        jalr_sum      = bus.ex_data1 + bus.ex_imm;
        actual_target = (bus.ex_op7 == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                : bus.ex_pc + bus.ex_imm;
        actual_next   = taken ? actual_target : bus.ex_pc + XLEN'(4);
        mispredict    = bus.ex_valid && (bus.ex_pred_target != actual_next);
        e_hit         = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    end

    // Decide how the resolved instruction updates its table entry
    always_comb begin
        tbl_we  = 1'b0;
        vld_clr = 1'b0;
        ctr_we  = 1'b0;
        ctr_d   = ctr_q[e_idx];
        if (bus.ex_valid) begin
            if (is_jump) begin
                tbl_we = 1'b1;
                ctr_we = 1'b1;
                ctr_d  = 2'b11;
            end else if (is_branch) begin
                if (taken) begin
                    tbl_we = 1'b1;
                    ctr_we = 1'b1;
                    ctr_d  = e_hit ? ctr_inc(ctr_q[e_idx]) : 2'b10;
                end else if (e_hit) begin
                    ctr_we = 1'b1;
                    ctr_d  = ctr_dec(ctr_q[e_idx]);
                end
            end else if (e_hit) begin
                vld_clr = 1'b1;
            end
        end
    end

    // Fetch PC: mispredict redirect beats stall, otherwise follow prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (mispredict) begin
            pc_q <= actual_next;
        end else if (!bus.stall) begin
            pc_q <= f_target;
        end
    end

    // Table control state: valid bits and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            if (tbl_we) begin
                valid_q[e_idx] <= 1'b1;
            end else if (vld_clr) begin
                valid_q[e_idx] <= 1'b0;
            end
            if (ctr_we) begin
                ctr_q[e_idx] <= ctr_d;
            end
        end
    end

    // Table data: tag and target, meaningful only while the entry is valid
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= actual_target;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = f_taken;
    assign bus.pred_target = f_target;
    assign bus.flush       = rst_n && mispredict;
    assign bus.redirect_pc = actual_next;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit with a queue-based scoreboard.
module tb_pc_predict_unit;
    logic clk;
    logic rst_n;

    pc_predict_if #(.XLEN(32)) bus ();

    pc_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;

    int total = 0;
    int bad   = 0;
    string       exp_name [$];
    logic [31:0] exp_val  [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input logic [31:0] v);
        exp_name.push_back(nm);
        exp_val.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       nm;
        logic [31:0] ev;
        total++;
        if (exp_name.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            nm = exp_name.pop_front();
            ev = exp_val.pop_front();
            assert (obs === ev) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", nm, obs, ev);
            end
        end
    endtask

    task automatic drive_ex(input logic [31:0] epc, input logic [6:0] op, input logic [2:0] bt,
                            input logic [31:0] d1, input logic [31:0] imm,
                            input logic eq, input logic lt, input logic ltu,
                            input logic [31:0] ptgt);
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = epc;
        bus.ex_op7         = op;
        bus.ex_b_t         = bt;
        bus.ex_data1       = d1;
        bus.ex_imm         = imm;
        bus.ex_breq        = eq;
        bus.ex_brlt        = lt;
        bus.ex_brltu       = ltu;
        bus.ex_pred_target = ptgt;
        bus.ex_pred_taken  = (ptgt != epc + 32'd4);
    endtask

    task automatic idle();
        bus.ex_valid = 1'b0;
    endtask

    // Move the fetch PC to addr via a mispredicted ALU op at addr-4
    task automatic goto_pc(input logic [31:0] addr);
        drive_ex(addr - 32'd4, OP_ALU, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ~addr);
        expect_val("goto_flush", 32'h1);
        #1;
        chk(32'(bus.flush));
        tick();
        idle();
        expect_val("goto_pc", addr);
        #1;
        chk(bus.pc);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b1;
        bus.ex_valid = 1'b0;
        bus.ex_pc = '0;
        bus.ex_op7 = '0;
        bus.ex_b_t = '0;
        bus.ex_data1 = '0;
        bus.ex_imm = '0;
        bus.ex_breq = 1'b0;
        bus.ex_brlt = 1'b0;
        bus.ex_brltu = 1'b0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_pred_target = '0;

        // Power-on reset
        tick();
        tick();
        expect_val("rst_pc", 32'h0);
        expect_val("rst_flush", 32'h0);
        expect_val("rst_pred_taken", 32'h0);
        expect_val("rst_pred_target", 32'h4);
        chk(bus.pc);
        chk(32'(bus.flush));
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);

        rst_n = 1'b1;
        bus.stall = 1'b0;
        expect_val("rel_pc0", 32'h0);
        #1;
        chk(bus.pc);
        tick();
        expect_val("rel_pc4", 32'h4);
        chk(bus.pc);
        tick();
        expect_val("rel_pc8", 32'h8);
        expect_val("rel_flush", 32'h0);
        chk(bus.pc);
        chk(32'(bus.flush));
        tick();

        // Mid-run reset with stall and a pending mispredict
        bus.stall = 1'b1;
        drive_ex(32'h100, OP_ALU, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_val("mid_pre_flush", 32'h1);
        #1;
        chk(32'(bus.flush));
        rst_n = 1'b0;
        expect_val("mid_rst_pc", 32'h0);
        expect_val("mid_rst_flush", 32'h0);
        #1;
        chk(bus.pc);
        chk(32'(bus.flush));
        tick();
        expect_val("mid_rst_pc_hold", 32'h0);
        expect_val("mid_rst_flush_hold", 32'h0);
        chk(bus.pc);
        chk(32'(bus.flush));
        idle();
        rst_n = 1'b1;
        bus.stall = 1'b0;
        tick();
        expect_val("mid_rel_pc4", 32'h4);
        chk(bus.pc);

        // Cold taken beq
        drive_ex(32'h10, OP_BR, 3'b000, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0, 32'h14);
        expect_val("beq_flush", 32'h1);
        expect_val("beq_redirect", 32'h30);
        #1;
        chk(32'(bus.flush));
        chk(bus.redirect_pc);
        tick();
        idle();
        expect_val("beq_pc", 32'h30);
        chk(bus.pc);

        goto_pc(32'h10);
        bus.stall = 1'b1;
        expect_val("beq_pred_taken", 32'h1);
        expect_val("beq_pred_target", 32'h30);
        #1;
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);

        // Taken again (ctr 10->11), correct prediction under stall
        drive_ex(32'h10, OP_BR, 3'b000, 32'h0, 32'h20, 1'b1, 1'b0, 1'b0, 32'h30);
        expect_val("beq2_flush", 32'h0);
        #1;
        chk(32'(bus.flush));
        tick();
        idle();
        expect_val("stall_hold_pc", 32'h10);
        chk(bus.pc);
        tick();
        expect_val("stall_hold_pc2", 32'h10);
        chk(bus.pc);

        // First not-taken (11->10) with stall: flush overrides stall
        drive_ex(32'h10, OP_BR, 3'b000, 32'h0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h30);
        expect_val("nt1_flush", 32'h1);
        expect_val("nt1_redirect", 32'h14);
        expect_val("nt1_same_cycle_pred", 32'h1);
        #1;
        chk(32'(bus.flush));
        chk(bus.redirect_pc);
        chk(32'(bus.pred_taken));
        tick();
        idle();
        expect_val("stall_flush_pc", 32'h14);
        chk(bus.pc);

        goto_pc(32'h10);
        expect_val("nt1_pred_taken", 32'h1);
        expect_val("nt1_pred_target", 32'h30);
        #1;
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);

        // Second not-taken (10->01), predicted correctly as fall-through
        drive_ex(32'h10, OP_BR, 3'b000, 32'h0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h14);
        expect_val("nt2_flush", 32'h0);
        expect_val("nt2_same_cycle_pred", 32'h1);
        #1;
        chk(32'(bus.flush));
        chk(32'(bus.pred_taken));
        tick();
        idle();
        expect_val("nt2_pc", 32'h10);
        expect_val("nt2_pred_taken", 32'h0);
        expect_val("nt2_pred_target", 32'h14);
        chk(bus.pc);
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);
        bus.stall = 1'b0;

        // JALR with LSB clear
        drive_ex(32'h40, OP_JALR, 3'b000, 32'h1001, 32'h4, 1'b0, 1'b0, 1'b0, 32'h44);
        expect_val("jalr_flush", 32'h1);
        expect_val("jalr_redirect", 32'h1004);
        #1;
        chk(32'(bus.flush));
        chk(bus.redirect_pc);
        tick();
        idle();
        expect_val("jalr_pc", 32'h1004);
        chk(bus.pc);
        goto_pc(32'h40);
        expect_val("jalr_pred_taken", 32'h1);
        expect_val("jalr_pred_target", 32'h1004);
        #1;
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);

        // Non-control instruction hitting the entry invalidates it
        bus.stall = 1'b1;
        drive_ex(32'h40, OP_ALU, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h44);
        expect_val("alias_flush", 32'h0);
        #1;
        chk(32'(bus.flush));
        tick();
        idle();
        expect_val("alias_pred_taken", 32'h0);
        expect_val("alias_pred_target", 32'h44);
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);
        bus.stall = 1'b0;

        // Unsigned branches and reserved funct3
        drive_ex(32'h80, OP_BR, 3'b110, 32'h0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h84);
        expect_val("bltu_flush", 32'h1);
        expect_val("bltu_redirect", 32'h180);
        #1;
        chk(32'(bus.flush));
        chk(bus.redirect_pc);
        tick();
        drive_ex(32'h90, OP_BR, 3'b111, 32'h0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h190);
        expect_val("bgeu_flush", 32'h1);
        expect_val("bgeu_redirect", 32'h94);
        #1;
        chk(32'(bus.flush));
        chk(bus.redirect_pc);
        tick();
        drive_ex(32'hA0, OP_BR, 3'b010, 32'h0, 32'h100, 1'b1, 1'b1, 1'b1, 32'h1A0);
        expect_val("bt010_flush", 32'h1);
        expect_val("bt010_redirect", 32'hA4);
        #1;
        chk(32'(bus.flush));
        chk(bus.redirect_pc);
        tick();
        idle();

        goto_pc(32'h80);
        expect_val("bltu_pred_taken", 32'h1);
        expect_val("bltu_pred_target", 32'h180);
        #1;
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);
        goto_pc(32'h90);
        expect_val("bgeu_pred_taken", 32'h0);
        expect_val("bgeu_pred_target", 32'h94);
        #1;
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);
        goto_pc(32'hA0);
        expect_val("bt010_pred_taken", 32'h0);
        expect_val("bt010_pred_target", 32'hA4);
        #1;
        chk(32'(bus.pred_taken));
        chk(bus.pred_target);

        // JAL with a negative offset
        drive_ex(32'hC0, OP_JAL, 3'b000, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 32'hC4);
        expect_val("jal_flush", 32'h1);
        expect_val("jal_redirect", 32'hB8);
        #1;
        chk(32'(bus.flush));
        chk(bus.redirect_pc);
        tick();
        idle();
        expect_val("jal_pc", 32'hB8);
        chk(bus.pc);

        // Other opcode resolves as fall-through
        drive_ex(32'hD0, OP_LD, 3'b000, 32'h0, 32'h40, 1'b1, 1'b1, 1'b1, 32'hD4);
        expect_val("load_flush", 32'h0);
        #1;
        chk(32'(bus.flush));
        tick();
        idle();

        expect_val("scoreboard_drained", 32'h0);
        chk(32'(exp_name.size() - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
